// File: rtl/spi_minion_pkg.sv
// Shared helpers for the SPI minion router / response-arbiter pair.
// Both blocks size their source-address field with addr_width().
package spi_minion_pkg;

    // Address field is never narrower than one bit, even with a single source.
    function automatic int addr_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/spi_minion_rr_arbiter.sv
// Round-robin grant over num_inputs requests; combinational grant, registered priority.
// The priority pointer advances past the winner only when en is high and a request is present.
module spi_minion_rr_arbiter
    import spi_minion_pkg::*;
#(
    parameter int num_inputs = 2,
    parameter int AW         = addr_width(num_inputs)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [num_inputs-1:0] req,
    input  logic                  en,
    output logic [num_inputs-1:0] grant,
    output logic [AW-1:0]         grant_idx
);

    logic [AW-1:0]         r_prio;
    logic [num_inputs-1:0] w_grant;
    logic [AW-1:0]         w_grant_idx;
    logic [AW-1:0]         w_next;
    logic [AW-1:0]         w_pos;
    logic                  w_found;
    int                    w_sum;

    // Scan upward from the priority pointer, wrapping at num_inputs.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_next      = '0;
        w_pos       = '0;
        w_found     = 1'b0;
        w_sum       = 0;
        for (int k = 0; k < num_inputs; k++) begin
            w_sum = int'(r_prio) + k;
            if (w_sum >= num_inputs) begin
                w_sum = w_sum - num_inputs;
            end
            w_pos = w_sum[AW-1:0];
            if (!w_found && req[w_pos]) begin
                w_found        = 1'b1;
                w_grant[w_pos] = 1'b1;
                w_grant_idx    = w_pos;
                w_next         = (w_pos == AW'(num_inputs - 1)) ? '0 : w_pos + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio <= '0;
        end else if (en && w_found) begin
            r_prio <= w_next;
        end
    end

    assign grant     = w_grant;
    assign grant_idx = w_grant_idx;

endmodule

// File: rtl/spi_minion_response_arbiter.sv
// Merges per-source response packets into one {source index, data} stream; one-cycle latency via a
// registered one-entry buffer that refills while draining; sources see no ready while it is full and stalled.
module spi_minion_response_arbiter
    import spi_minion_pkg::*;
#(
    parameter int nbits      = 4,
    parameter int num_inputs = 2,
    parameter int addr_nbits = addr_width(num_inputs)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [num_inputs-1:0][nbits-1:0] recv_msg,
    input  logic [num_inputs-1:0]            recv_val,
    output logic [num_inputs-1:0]            recv_rdy,
    output logic [addr_nbits+nbits-1:0]      send_msg,
    output logic                             send_val,
    input  logic                             send_rdy
);

    localparam int AW = addr_width(num_inputs);

    logic                        r_buf_full;
    logic [addr_nbits+nbits-1:0] r_buf_msg;

    logic                        w_accept_en;
    logic                        w_xfer;
    logic [num_inputs-1:0]       w_grant;
    logic [AW-1:0]               w_grant_idx;

    // Accepting while the adapter drains keeps throughput at one packet per cycle.
    assign w_accept_en = (!r_buf_full || send_rdy) && !reset;
    assign w_xfer      = w_accept_en && (|w_grant);
    assign recv_rdy    = w_accept_en ? w_grant : '0;

    spi_minion_rr_arbiter #(
        .num_inputs (num_inputs),
        .AW         (AW)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (recv_val),
        .en        (w_accept_en),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_full <= 1'b0;
            r_buf_msg  <= '0;
        end else if (w_xfer) begin
            r_buf_full <= 1'b1;
            r_buf_msg  <= {addr_nbits'(w_grant_idx), recv_msg[w_grant_idx]};
        end else if (r_buf_full && send_rdy) begin
            r_buf_full <= 1'b0;
        end
    end

    assign send_val = r_buf_full;
    assign send_msg = r_buf_msg;

endmodule

// File: tb/tb_spi_minion_response_arbiter.sv
// Directed bench for the response arbiter: a 2-source instance and a 3-source instance.
module tb_spi_minion_response_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Two-source instance (nbits=4, addr 1 bit)
    logic            reset2;
    logic [1:0][3:0] msg2;
    logic [1:0]      val2;
    logic [1:0]      rdy2;
    logic [4:0]      smsg2;
    logic            sval2;
    logic            srdy2;

    // Three-source instance (nbits=4, addr 2 bits)
    logic            reset3;
    logic [2:0][3:0] msg3;
    logic [2:0]      val3;
    logic [2:0]      rdy3;
    logic [5:0]      smsg3;
    logic            sval3;
    logic            srdy3;

    spi_minion_response_arbiter #(.nbits(4), .num_inputs(2)) dut2 (
        .clk      (clk),
        .reset    (reset2),
        .recv_msg (msg2),
        .recv_val (val2),
        .recv_rdy (rdy2),
        .send_msg (smsg2),
        .send_val (sval2),
        .send_rdy (srdy2)
    );

    spi_minion_response_arbiter #(.nbits(4), .num_inputs(3)) dut3 (
        .clk      (clk),
        .reset    (reset3),
        .recv_msg (msg3),
        .recv_val (val3),
        .recv_rdy (rdy3),
        .send_msg (smsg3),
        .send_val (sval3),
        .send_rdy (srdy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; return 1 time unit after it so registered outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        reset2 = 1'b1; msg2 = '0; val2 = 2'($urandom_range(0, 3)); srdy2 = 1'b1;
        reset3 = 1'b1; msg3 = '0; val3 = 3'b000;                   srdy3 = 1'b1;

        // Reset held for two cycles with random valids
        tick();
        val2 = 2'($urandom_range(0, 3)); settle();
        check("rst_rdy_a", 32'(rdy2), 32'h0);
        check("rst_val_a", 32'(sval2), 32'h0);
        check("rst_msg_a", 32'(smsg2), 32'h0);
        tick();
        val2 = 2'b11; settle();
        check("rst_rdy_b", 32'(rdy2), 32'h0);
        check("rst_val_b", 32'(sval2), 32'h0);

        // Round-robin: both valid, first grant goes to source 0
        reset2 = 1'b0; msg2[0] = 4'h3; msg2[1] = 4'h5; settle();
        check("rr_rdy0", 32'(rdy2), 32'h1);
        tick(); settle();
        check("rr_msg0", 32'(smsg2), 32'h03);
        check("rr_val0", 32'(sval2), 32'h1);
        check("rr_rdy1", 32'(rdy2), 32'h2);
        tick();
        check("rr_msg1", 32'(smsg2), 32'h15);
        tick();
        check("rr_msg2", 32'(smsg2), 32'h03);
        check("rr_val2", 32'(sval2), 32'h1);
        tick();
        check("rr_msg3", 32'(smsg2), 32'h15);

        // Single source 1 (prio is back at 0)
        val2 = 2'b10; msg2[1] = 4'hA; settle();
        check("single_rdy", 32'(rdy2), 32'h2);
        tick();
        check("single_msg", 32'(smsg2), 32'h1A);
        check("single_val", 32'(sval2), 32'h1);

        // Drain without refill: valid drops, message holds
        val2 = 2'b00; settle();
        check("drain_rdy", 32'(rdy2), 32'h0);
        tick();
        check("drain_val", 32'(sval2), 32'h0);
        check("drain_msg", 32'(smsg2), 32'h1A);

        // Backpressure: load 0_0111 then stall with source 1 valid
        val2 = 2'b01; msg2[0] = 4'h7; srdy2 = 1'b0; settle();
        check("bp_load_rdy", 32'(rdy2), 32'h1);
        tick();
        check("bp_load_msg", 32'(smsg2), 32'h07);
        val2 = 2'b10; msg2[1] = 4'h9;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("bp_stall_rdy", 32'(rdy2), 32'h0);
            tick();
            check("bp_stall_msg", 32'(smsg2), 32'h07);
            check("bp_stall_val", 32'(sval2), 32'h1);
        end
        srdy2 = 1'b1; settle();
        check("bp_release_rdy", 32'(rdy2), 32'h2);
        tick();
        check("bp_release_msg", 32'(smsg2), 32'h19);
        check("bp_release_val", 32'(sval2), 32'h1);

        // Priority hold: source 1 stalled, source 0 joins; prio stays 0
        srdy2 = 1'b0; val2 = 2'b10; msg2[0] = 4'h2; settle();
        check("ph_stall_rdy", 32'(rdy2), 32'h0);
        tick();
        val2 = 2'b11; settle();
        check("ph_stall2_rdy", 32'(rdy2), 32'h0);
        tick();
        check("ph_hold_msg", 32'(smsg2), 32'h19);
        srdy2 = 1'b1; settle();
        check("ph_first_rdy", 32'(rdy2), 32'h1);
        tick();
        check("ph_first_msg", 32'(smsg2), 32'h02);
        check("ph_second_rdy", 32'(rdy2), 32'h2);
        tick();
        check("ph_second_msg", 32'(smsg2), 32'h19);
        val2 = 2'b00;

        // Three sources: address fields rotate 00, 01, 10, 00
        reset3 = 1'b0; val3 = 3'b111;
        msg3[0] = 4'h1; msg3[1] = 4'h2; msg3[2] = 4'h3; settle();
        check("n3_rdy0", 32'(rdy3), 32'h1);
        tick();
        check("n3_msg0", 32'(smsg3), 32'h01);
        tick();
        check("n3_msg1", 32'(smsg3), 32'h12);
        tick();
        check("n3_msg2", 32'(smsg3), 32'h23);
        tick();
        check("n3_msg3", 32'(smsg3), 32'h01);
        check("n3_val3", 32'(sval3), 32'h1);

        // Reset while the buffer is full
        reset3 = 1'b1; settle();
        check("n3_rst_rdy", 32'(rdy3), 32'h0);
        tick();
        check("n3_rst_val", 32'(sval3), 32'h0);
        check("n3_rst_msg", 32'(smsg3), 32'h0);
        reset3 = 1'b0; settle();
        check("n3_after_rst_rdy", 32'(rdy3), 32'h1);
        tick();
        check("n3_after_rst_msg", 32'(smsg3), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
